reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised, pipeline-aware general-purpose register file for the datapath: two combinational read ports, one synchronous write port, optional hard-wired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard that flags read-after-write hazards to the decode stage. After reset, an internal sequencer clears every register to zero, one register per clock. The block replaces the fixed 32×32 register file between decode (RA/RB) and writeback (RY) and keeps its debug view port.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1: 1 = register 0 always reads 0; writes to it are discarded and it never becomes pending.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports.
- CLEAR_ON_RESET, 1: 1 = clear all registers after reset; 0 = skip clearing (contents undefined until written).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- Rsrc1, Rsrc2  in  ADDR_W  read addresses for RA and RB.
- RA, RB  out  DATA_W  read data.
- Rdst  in  ADDR_W  write address.
- RY  in  DATA_W  write data.
- RF_WRITE  in  1  write enable.
- RF_RESERVE  in  1  marks Rres as pending (instruction issued with this destination).
- Rres  in  ADDR_W  address to reserve.
- HAZARD1, HAZARD2  out  1  Rsrc1/Rsrc2 pending and not satisfied this cycle.
- busy  out  1  clear sequence in progress; all inputs except reset are ignored.
- RegFileView_Select  in  ADDR_W  debug view address.
- RegFileRegisterToView  out  DATA_W  debug view data (raw array, no bypass).

## Operation
- States: CLEAR, RUN. Reset high: state <= CLEAR if CLEAR_ON_RESET, else RUN; clear counter <= 0; all pending bits <= 0.
- CLEAR (reset low): each cycle writes 0 to R[cnt] and increments cnt. When cnt == DEPTH-1, that write completes and the state moves to RUN. busy = (state == CLEAR), so busy is also 1 while reset is high if CLEAR_ON_RESET = 1.
- During CLEAR: RF_WRITE and RF_RESERVE are ignored. RA, RB, RegFileRegisterToView = 0. HAZARD1/2 = 0.
- Reset asserted mid-CLEAR restarts the sequence at cnt = 0. Reset during RUN drops all pending bits and re-enters CLEAR. Register contents are not altered during the reset cycle itself.
- RUN write: on posedge with RF_WRITE, R[Rdst] <= RY unless ZERO_REG and Rdst == 0. The write also clears pending[Rdst].
- Read: RAx = 0 if ZERO_REG and addr == 0. Otherwise, if BYPASS, RF_WRITE, and Rdst == addr, RAx = RY. Otherwise RAx = R[addr]. RA and RB are evaluated independently.
- Reserve: on posedge with RF_RESERVE in RUN, pending[Rres] <= 1, except when ZERO_REG and Rres == 0.
- Same-cycle RF_WRITE and RF_RESERVE to the same address: the data is written and pending ends at 1, because the newer instruction wins.
- HAZARDx = pending[addr] AND NOT (BYPASS AND RF_WRITE AND Rdst == addr). HAZARDx is 0 for a zero register, and 0 in CLEAR.
- Width rules: no arithmetic on data. The counter is ADDR_W bits and does not wrap past DEPTH-1 in CLEAR.

## Timing
- Read ports and HAZARD outputs are combinational from their addresses, the state, and (with bypass) same-cycle write inputs. Latency is 0.
- Write latency is 1 clock. Without BYPASS, the value is visible on RA/RB in the cycle after the RF_WRITE edge.
- The clear takes exactly DEPTH cycles after reset deasserts. busy falls on the edge that performs the write of R[DEPTH-1]. The first RUN cycle accepts writes.
- Reset values: busy = CLEAR_ON_RESET; RA = RB = RegFileRegisterToView = 0 while busy; HAZARD1 = HAZARD2 = 0; all pending = 0.
- The debug view shows array contents only and lags writes by 1 clock.

## Test plan
- Reset clear, with ADDR_W=5 and every register preloaded to 0xDEADBEEF: pulse reset for 1 cycle -> busy stays high for exactly 32 cycles, then falls. All 32 registers read 0 through the view port. A write attempted during busy has no effect.
- Reset mid-clear: reassert reset at cnt = 10 -> the counter restarts, and busy stays high for 32 cycles after the second release.
- Zero register: write 0x12345678 to R0, then read Rsrc1 = 0 -> RA = 0. Reserve R0 -> HAZARD1 stays 0.
- Bypass, with R5 = 0x11: in one cycle set RF_WRITE, Rdst = 5, RY = 0xAA, Rsrc1 = Rsrc2 = 5 -> RA = RB = 0xAA in the same cycle. With BYPASS = 0 -> 0x11 that cycle, then 0xAA the next cycle.
- Scoreboard: reserve R7; next cycle Rsrc2 = 7 -> HAZARD2 = 1. Write R7 = 0x55 with BYPASS = 1 -> HAZARD2 = 0 that cycle and RB = 0x55. After the write, pending is cleared.
- Simultaneous reserve and write to R9 -> R9 holds the new data, and HAZARD1 = 1 on the next cycle for Rsrc1 = 9. Reset then clears all pending bits.

Source files
------------

// File: rtl/reg_file_param_if.sv
// reg_file_param_if: decode/writeback/debug bus of the register file
interface reg_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Rsrc1, Rsrc2, Rdst, Rres, RegFileView_Select;
  logic [DATA_W-1:0] RA, RB, RY, RegFileRegisterToView;
  logic RF_WRITE, RF_RESERVE, HAZARD1, HAZARD2, busy;
  modport master (
    output Rsrc1, Rsrc2, Rdst, RY, RF_WRITE, RF_RESERVE, Rres, RegFileView_Select,
    input RA, RB, HAZARD1, HAZARD2, busy, RegFileRegisterToView
  );
  modport slave (
    input Rsrc1, Rsrc2, Rdst, RY, RF_WRITE, RF_RESERVE, Rres, RegFileView_Select,
    output RA, RB, HAZARD1, HAZARD2, busy, RegFileRegisterToView
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: 2R/1W register file with bypass, hazard scoreboard and post-reset clear
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic run, z1, z2, f1, f2, wz, rz;
  assign run = state == RUN;
  assign z1 = ZERO_REG != 0 && bus.Rsrc1 == '0;
  assign z2 = ZERO_REG != 0 && bus.Rsrc2 == '0;
  assign wz = ZERO_REG != 0 && bus.Rdst == '0;
  assign rz = ZERO_REG != 0 && bus.Rres == '0;
  assign f1 = BYPASS != 0 && bus.RF_WRITE && bus.Rdst == bus.Rsrc1;
  assign f2 = BYPASS != 0 && bus.RF_WRITE && bus.Rdst == bus.Rsrc2;
  assign bus.busy = !run;
  assign bus.RA = (!run || z1) ? '0 : f1 ? bus.RY : regs[bus.Rsrc1];
  assign bus.RB = (!run || z2) ? '0 : f2 ? bus.RY : regs[bus.Rsrc2];
  assign bus.HAZARD1 = run && !z1 && !f1 && pending[bus.Rsrc1];
  assign bus.HAZARD2 = run && !z2 && !f2 && pending[bus.Rsrc2];
  assign bus.RegFileRegisterToView = run ? regs[bus.RegFileView_Select] : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) regs[cnt] <= '0;
      else if (bus.RF_WRITE && !wz) regs[bus.Rdst] <= bus.RY;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      cnt <= '0;
      pending <= '0;
    end else if (!run) begin
      cnt <= cnt == LAST ? cnt : cnt + 1'b1;
      state <= cnt == LAST ? RUN : CLEAR;
    end else begin
      if (bus.RF_WRITE) pending[bus.Rdst] <= 1'b0;
      if (bus.RF_RESERVE && !rz) pending[bus.Rres] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of clear, zero reg, bypass and scoreboard
module tb_reg_file_param;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  reg_file_param_if ia ();
  reg_file_param_if ib ();
  reg_file_param dut_a (.clk(clk), .reset(reset), .bus(ia));
  reg_file_param #(.BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  assign ib.Rsrc1 = ia.Rsrc1;
  assign ib.Rsrc2 = ia.Rsrc2;
  assign ib.Rdst = ia.Rdst;
  assign ib.RY = ia.RY;
  assign ib.RF_WRITE = ia.RF_WRITE;
  assign ib.RF_RESERVE = ia.RF_RESERVE;
  assign ib.Rres = ia.Rres;
  assign ib.RegFileView_Select = ia.RegFileView_Select;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    ia.RF_WRITE = 1'b0;
    ia.RF_RESERVE = 1'b0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ia.RF_WRITE = 1'b1;
    ia.Rdst = a;
    ia.RY = d;
    tick();
    idle();
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic wait_clear(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk(tag, {31'd0, ia.busy}, {31'd0, i < 32});
    end
  endtask
  initial begin
    idle();
    reset = 1'b1;
    ia.Rsrc1 = 5'd5;
    ia.Rsrc2 = 5'd6;
    ia.Rdst = 5'd0;
    ia.RY = '0;
    ia.Rres = 5'd0;
    ia.RegFileView_Select = 5'd5;
    tick();
    tick();
    chk("rst_busy", {31'd0, ia.busy}, 32'd1);
    chk("rst_ra", ia.RA, 32'd0);
    chk("rst_view", ia.RegFileRegisterToView, 32'd0);
    chk("rst_haz", {30'd0, ia.HAZARD1, ia.HAZARD2}, 32'd0);
    reset = 1'b0;
    wait_clear("init_busy");
    for (int i = 0; i < 32; i++) wr(5'(i), 32'hDEADBEEF);
    ia.RegFileView_Select = 5'd5;
    #1;
    chk("preload_r5", ia.RegFileRegisterToView, 32'hDEADBEEF);
    ia.RegFileView_Select = 5'd0;
    #1;
    chk("preload_r0", ia.RegFileRegisterToView, 32'd0);
    pulse_reset();
    chk("clr_busy0", {31'd0, ia.busy}, 32'd1);
    chk("clr_ra", ia.RA, 32'd0);
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) begin
        ia.RF_WRITE = 1'b1;
        ia.Rdst = 5'd2;
        ia.RY = 32'h99;
        ia.RF_RESERVE = 1'b1;
        ia.Rres = 5'd4;
      end
      tick();
      idle();
      chk("clr_busy", {31'd0, ia.busy}, {31'd0, i < 32});
    end
    for (int i = 0; i < 32; i++) begin
      ia.RegFileView_Select = 5'(i);
      #1;
      chk($sformatf("clr_view%0d", i), ia.RegFileRegisterToView, 32'd0);
    end
    ia.Rsrc1 = 5'd4;
    #1;
    chk("busy_reserve_ignored", {31'd0, ia.HAZARD1}, 32'd0);
    pulse_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'd0, ia.busy}, 32'd1);
    pulse_reset();
    wait_clear("mid_restart");
    wr(5'd0, 32'h12345678);
    ia.Rsrc1 = 5'd0;
    #1;
    chk("zero_ra", ia.RA, 32'd0);
    chk("zero_ra_nb", ib.RA, 32'd0);
    ia.RF_RESERVE = 1'b1;
    ia.Rres = 5'd0;
    tick();
    idle();
    chk("zero_haz", {31'd0, ia.HAZARD1}, 32'd0);
    wr(5'd5, 32'h11);
    ia.RF_WRITE = 1'b1;
    ia.Rdst = 5'd5;
    ia.RY = 32'hAA;
    ia.Rsrc1 = 5'd5;
    ia.Rsrc2 = 5'd5;
    ia.RegFileView_Select = 5'd5;
    #1;
    chk("byp_ra", ia.RA, 32'hAA);
    chk("byp_rb", ia.RB, 32'hAA);
    chk("nobyp_ra", ib.RA, 32'h11);
    chk("nobyp_rb", ib.RB, 32'h11);
    chk("byp_view_lag", ia.RegFileRegisterToView, 32'h11);
    tick();
    idle();
    chk("nobyp_ra_next", ib.RA, 32'hAA);
    chk("byp_view_next", ia.RegFileRegisterToView, 32'hAA);
    ia.RF_RESERVE = 1'b1;
    ia.Rres = 5'd7;
    tick();
    idle();
    ia.Rsrc2 = 5'd7;
    #1;
    chk("sb_haz2", {31'd0, ia.HAZARD2}, 32'd1);
    chk("sb_haz2_nb", {31'd0, ib.HAZARD2}, 32'd1);
    chk("sb_haz1_other", {31'd0, ia.HAZARD1}, 32'd0);
    ia.RF_WRITE = 1'b1;
    ia.Rdst = 5'd7;
    ia.RY = 32'h55;
    #1;
    chk("sb_haz2_byp", {31'd0, ia.HAZARD2}, 32'd0);
    chk("sb_rb_byp", ia.RB, 32'h55);
    chk("sb_haz2_nobyp", {31'd0, ib.HAZARD2}, 32'd1);
    tick();
    idle();
    chk("sb_cleared", {31'd0, ia.HAZARD2}, 32'd0);
    chk("sb_cleared_nb", {31'd0, ib.HAZARD2}, 32'd0);
    chk("sb_rb_nb", ib.RB, 32'h55);
    ia.Rsrc1 = 5'd5;
    #1;
    chk("indep_ra", ia.RA, 32'hAA);
    chk("indep_rb", ia.RB, 32'h55);
    ia.RF_WRITE = 1'b1;
    ia.Rdst = 5'd9;
    ia.RY = 32'h77;
    ia.RF_RESERVE = 1'b1;
    ia.Rres = 5'd9;
    tick();
    idle();
    ia.Rsrc1 = 5'd9;
    #1;
    chk("same_haz1", {31'd0, ia.HAZARD1}, 32'd1);
    chk("same_data", ia.RA, 32'h77);
    pulse_reset();
    chk("rst_haz_busy", {31'd0, ia.HAZARD1}, 32'd0);
    wait_clear("final_clear");
    chk("rst_pending", {31'd0, ia.HAZARD1}, 32'd0);
    chk("rst_pending_nb", {31'd0, ib.HAZARD1}, 32'd0);
    chk("final_r9", ia.RA, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
